pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: DRAIN_CYCLES, 3, number of cycles that EX/MEM/WB drain before interrupt PC push (legal 1..7).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: interrupt_signal  in  1  level interrupt request from the pin.
REQ-005 SHALL have port: id_rsrc1, id_rsrc2  in  3 each  source register fields of the instruction in decode.
REQ-006 SHALL have port: id_uses_src1, id_uses_src2  in  1 each  decode instruction reads that source.
REQ-007 SHALL have port: ex_mem_read, ex_rdst  in  1, 3  execute-stage load flag and its destination register.
REQ-008 SHALL have port: branch_taken  in  1  taken jump/call/ret resolved this cycle.
REQ-009 SHALL have port: pc_stall, if_id_stall  out  1 each  hold PC and the IF/ID register.
REQ-010 SHALL have port: id_ex_bubble  out  1  force all ID/EX control bits to zero.
REQ-011 SHALL have port: if_id_flush  out  1  clear the IF/ID instruction to NOP.
REQ-012 SHALL have port: int_push_hi, int_push_lo  out  1 each  push PC[31:16] / PC[15:0] onto the stack.
REQ-013 SHALL have port: int_pc_load  out  1  load PC from the interrupt vector (memory word 0).
REQ-014 SHALL have port: int_busy  out  1  interrupt sequence in progress.

Function
REQ-015 SHALL detect load-use when ex_mem_read=1 and ((id_uses_src1 and id_rsrc1==ex_rdst) or (id_uses_src2 and id_rsrc2==ex_rdst)).
REQ-016 On load-use, pc_stall, if_id_stall and id_ex_bubble SHALL all be 1 in the same cycle (combinational, zero latency).
REQ-017 The load-use stall SHALL last exactly one cycle per hazardous load; the bubble removes the condition in the next cycle.
REQ-018 On branch_taken=1, if_id_flush SHALL be 1 in the same cycle, and id_ex_bubble SHALL also be 1.
REQ-019 If branch_taken and load-use occur together, the flush SHALL win: if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0.
REQ-020 A rising interrupt_signal SHALL set a sticky int_pending flag; further edges while pending or busy SHALL be ignored.
REQ-021 The FSM SHALL have states IDLE, DRAIN, PUSH_HI, PUSH_LO and VECTOR.
REQ-022 IDLE->DRAIN SHALL occur when int_pending=1, branch_taken=0 and no load-use; otherwise it stays in IDLE with the request still pending.
REQ-023 DRAIN SHALL last exactly DRAIN_CYCLES cycles, counted by a 3-bit down-counter; pc_stall=1, if_id_stall=1 and id_ex_bubble=1 throughout.
REQ-024 DRAIN->PUSH_HI->PUSH_LO->VECTOR->IDLE SHALL take one cycle each.
REQ-025 int_push_hi SHALL be 1 only in PUSH_HI and int_push_lo only in PUSH_LO; id_ex_bubble=1 and pc_stall=1 in both.
REQ-026 In VECTOR, int_pc_load=1 and if_id_flush=1, and int_pending SHALL clear.
REQ-027 int_busy SHALL be 1 in every state except IDLE.
REQ-028 While int_busy=1, branch_taken and load-use SHALL be ignored, and the FSM-state outputs SHALL take precedence.
REQ-029 Total interrupt latency from the accepting IDLE cycle to int_pc_load SHALL be DRAIN_CYCLES+3 cycles.

Reset
REQ-030 When reset=0, the block SHALL go asynchronously to state IDLE with int_pending=0 and the drain counter at 0.
REQ-031 During reset, every registered output SHALL be 0; combinational hazard outputs SHALL be forced to 0.
REQ-032 Reset during any interrupt state SHALL abort the sequence; no push or vector strobe is issued after reset is released.

Verification
REQ-033 Load r3 in EX (ex_mem_read=1, ex_rdst=3) with ID id_rsrc1=3, id_uses_src1=1 -> pc_stall, if_id_stall and id_ex_bubble are 1 for exactly one cycle.
REQ-034 Same load with id_uses_src1=0, id_rsrc2=3, id_uses_src2=0 -> no stall.
REQ-035 branch_taken=1 together with the load-use hazard of REQ-033 -> if_id_flush=1, id_ex_bubble=1, pc_stall=0.
REQ-036 Interrupt pulse in IDLE with DRAIN_CYCLES=3 -> int_busy for 6 cycles, int_push_hi at cycle 4, int_push_lo at cycle 5, int_pc_load at cycle 6, then IDLE.
REQ-037 Interrupt pulse coincident with branch_taken=1 -> acceptance delayed one cycle; the sequence then completes normally.
REQ-038 reset=0 asserted in PUSH_HI -> all outputs 0 immediately; after release, no int_push_lo occurs and the FSM is in IDLE.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode/execute hazard inputs, interrupt pin and control strobes
interface pipe_hazard_ctrl_if;
  logic       interrupt_signal;
  logic [2:0] id_rsrc1;
  logic [2:0] id_rsrc2;
  logic       id_uses_src1;
  logic       id_uses_src2;
  logic       ex_mem_read;
  logic [2:0] ex_rdst;
  logic       branch_taken;
  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       int_push_hi;
  logic       int_push_lo;
  logic       int_pc_load;
  logic       int_busy;
  modport master (
    output interrupt_signal, id_rsrc1, id_rsrc2, id_uses_src1, id_uses_src2,
           ex_mem_read, ex_rdst, branch_taken,
    input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush,
           int_push_hi, int_push_lo, int_pc_load, int_busy
  );
  modport slave (
    input  interrupt_signal, id_rsrc1, id_rsrc2, id_uses_src1, id_uses_src2,
           ex_mem_read, ex_rdst, branch_taken,
    output pc_stall, if_id_stall, id_ex_bubble, if_id_flush,
           int_push_hi, int_push_lo, int_pc_load, int_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and interrupt entry sequencing
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR} state_t;
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
  state_t     state, state_nxt;
  logic [2:0] drain_cnt, drain_cnt_nxt;
  logic       int_pending, int_prev;
  logic       load_use, branch, int_rise, int_req;
  assign load_use = reset && bus.ex_mem_read &&
                    ((bus.id_uses_src1 && bus.id_rsrc1 == bus.ex_rdst) ||
                     (bus.id_uses_src2 && bus.id_rsrc2 == bus.ex_rdst));
  assign branch   = reset && bus.branch_taken;
  assign int_rise = bus.interrupt_signal && !int_prev;
  assign int_req  = int_pending || int_rise;
  // state, drain counter and sticky interrupt request; prev starts high so a held pin cannot retrigger after reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      drain_cnt   <= 3'd0;
      int_pending <= 1'b0;
      int_prev    <= 1'b1;
    end else begin
      state       <= state_nxt;
      drain_cnt   <= drain_cnt_nxt;
      int_pending <= state == VECTOR ? 1'b0 : (state == IDLE && int_rise) ? 1'b1 : int_pending;
      int_prev    <= bus.interrupt_signal;
    end
  // next state and strobes; any busy state overrides hazard handling
  always_comb begin
    state_nxt        = state;
    drain_cnt_nxt    = drain_cnt;
    bus.pc_stall     = 1'b0;
    bus.if_id_stall  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.int_push_hi  = 1'b0;
    bus.int_push_lo  = 1'b0;
    bus.int_pc_load  = 1'b0;
    bus.int_busy     = state != IDLE;
    unique case (state)
      IDLE: begin
        bus.pc_stall     = load_use && !branch;
        bus.if_id_stall  = load_use && !branch;
        bus.id_ex_bubble = load_use || branch;
        bus.if_id_flush  = branch;
        state_nxt        = (int_req && !load_use && !branch) ? DRAIN : IDLE;
        drain_cnt_nxt    = (int_req && !load_use && !branch) ? DRAIN_LOAD : drain_cnt;
      end
      DRAIN: begin
        bus.pc_stall     = 1'b1;
        bus.if_id_stall  = 1'b1;
        bus.id_ex_bubble = 1'b1;
        state_nxt        = drain_cnt == 3'd0 ? PUSH_HI : DRAIN;
        drain_cnt_nxt    = drain_cnt == 3'd0 ? 3'd0 : drain_cnt - 3'd1;
      end
      PUSH_HI: begin
        bus.pc_stall     = 1'b1;
        bus.if_id_stall  = 1'b1;
        bus.id_ex_bubble = 1'b1;
        bus.int_push_hi  = 1'b1;
        state_nxt        = PUSH_LO;
      end
      PUSH_LO: begin
        bus.pc_stall     = 1'b1;
        bus.if_id_stall  = 1'b1;
        bus.id_ex_bubble = 1'b1;
        bus.int_push_lo  = 1'b1;
        state_nxt        = VECTOR;
      end
      VECTOR: begin
        bus.id_ex_bubble = 1'b1;
        bus.if_id_flush  = 1'b1;
        bus.int_pc_load  = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of hazard and interrupt control
module tb_pipe_hazard_ctrl;
  localparam int D = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.DRAIN_CYCLES(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  int ipos = 0;
  bit pend = 1'b0;
  bit prv = 1'b1;
  // observed vector: {pc_stall, if_id_stall, bubble, flush, push_hi, push_lo, pc_load, busy}
  function automatic logic [7:0] obs();
    return {bus.pc_stall, bus.if_id_stall, bus.id_ex_bubble, bus.if_id_flush,
            bus.int_push_hi, bus.int_push_lo, bus.int_pc_load, bus.int_busy};
  endfunction
  function automatic bit lu_now();
    return bus.ex_mem_read && ((bus.id_uses_src1 && bus.id_rsrc1 == bus.ex_rdst) ||
                               (bus.id_uses_src2 && bus.id_rsrc2 == bus.ex_rdst));
  endfunction
  function automatic logic [7:0] seq_exp(int i);
    return i <= D ? 8'b1110_0001 : i == D + 1 ? 8'b1110_1001 : i == D + 2 ? 8'b1110_0101 : 8'b0011_0011;
  endfunction
  function automatic logic [7:0] model();
    bit lu = lu_now();
    bit br = bus.branch_taken;
    if (!reset) return 8'h00;
    if (ipos == 0) return {lu && !br, lu && !br, lu || br, br, 4'b0000};
    return seq_exp(ipos);
  endfunction
  function automatic void upd();
    bit rise = bus.interrupt_signal && !prv;
    if (!reset) begin
      ipos = 0;
      pend = 1'b0;
      prv = 1'b1;
      return;
    end
    if (ipos == 0) begin
      if (rise) pend = 1'b1;
      if (pend && !bus.branch_taken && !lu_now()) ipos = 1;
    end else if (ipos == D + 3) begin
      ipos = 0;
      pend = 1'b0;
    end else ipos++;
    prv = bus.interrupt_signal;
  endfunction
  task automatic chk(string tag, logic [7:0] exp);
    logic [7:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, o, exp);
    end
  endtask
  task automatic step(string tag);
    @(negedge clk);
    chk(tag, model());
    @(posedge clk);
    upd();
    #1;
  endtask
  task automatic stepk(string tag, logic [7:0] exp);
    @(negedge clk);
    chk(tag, model());
    chk({tag, "_k"}, exp);
    @(posedge clk);
    upd();
    #1;
  endtask
  task automatic idle();
    bus.interrupt_signal = 1'b0;
    bus.id_rsrc1 = 3'd0;
    bus.id_rsrc2 = 3'd0;
    bus.id_uses_src1 = 1'b0;
    bus.id_uses_src2 = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rdst = 3'd0;
    bus.branch_taken = 1'b0;
  endtask
  task automatic hazard();
    bus.ex_mem_read = 1'b1;
    bus.ex_rdst = 3'd3;
    bus.id_rsrc1 = 3'd3;
    bus.id_uses_src1 = 1'b1;
  endtask
  task automatic int_seq(string tag);
    for (int i = 1; i <= D + 3; i++) begin
      if (i == 2) begin
        hazard();
        bus.branch_taken = 1'b1;
      end
      if (i == 3) bus.interrupt_signal = 1'b1;
      if (i == 4) bus.interrupt_signal = 1'b0;
      if (i == D + 3) begin
        bus.branch_taken = 1'b0;
        bus.ex_mem_read = 1'b0;
      end
      stepk(tag, seq_exp(i));
    end
  endtask
  initial begin
    idle();
    hazard();
    bus.branch_taken = 1'b1;
    bus.interrupt_signal = 1'b1;
    #3 chk("reset_outputs", 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle();
    hazard();
    stepk("lu_stall", 8'b1110_0000);
    bus.ex_mem_read = 1'b0;
    stepk("lu_bubbled", 8'h00);
    bus.ex_mem_read = 1'b1;
    bus.id_uses_src1 = 1'b0;
    bus.id_rsrc2 = 3'd3;
    stepk("lu_unused", 8'h00);
    bus.id_uses_src2 = 1'b1;
    stepk("lu_src2", 8'b1110_0000);
    idle();
    hazard();
    bus.branch_taken = 1'b1;
    stepk("br_wins", 8'b0011_0000);
    bus.ex_mem_read = 1'b0;
    stepk("br_only", 8'b0011_0000);
    idle();
    bus.interrupt_signal = 1'b1;
    stepk("int_accept", 8'h00);
    bus.interrupt_signal = 1'b0;
    int_seq("int_seq");
    idle();
    stepk("int_done", 8'h00);
    stepk("int_no_rerun", 8'h00);
    bus.interrupt_signal = 1'b1;
    bus.branch_taken = 1'b1;
    stepk("int_br_defer", 8'b0011_0000);
    idle();
    stepk("int_accept2", 8'h00);
    int_seq("int_seq2");
    idle();
    stepk("int_done2", 8'h00);
    bus.interrupt_signal = 1'b1;
    stepk("int_accept3", 8'h00);
    bus.interrupt_signal = 1'b0;
    for (int i = 1; i <= D; i++) stepk("int_drain3", 8'b1110_0001);
    @(negedge clk);
    chk("push_hi_pre_rst", 8'b1110_1001);
    #1 reset = 1'b0;
    #1 chk("rst_async", 8'h00);
    upd();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < D + 4; i++) stepk("post_rst_idle", 8'h00);
    for (int i = 0; i < 500; i++) begin
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.ex_rdst = 3'($urandom_range(0, 3));
      bus.id_rsrc1 = 3'($urandom_range(0, 3));
      bus.id_rsrc2 = 3'($urandom_range(0, 3));
      bus.id_uses_src1 = 1'($urandom_range(0, 1));
      bus.id_uses_src2 = 1'($urandom_range(0, 1));
      bus.branch_taken = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 7) == 0) bus.interrupt_signal = ~bus.interrupt_signal;
      step("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
